nibble_add_scheduler: RTL
=========================

Name: nibble_add_scheduler

Overview:
- Shares one 4-bit adder slice (with carry-in) among NREQ requesters.
- Arbitrates round-robin, captures the winner's WIDTH-bit operands, then adds them one nibble per cycle, LSB nibble first, with a registered carry between nibbles.
- Returns a tagged sum with a one-cycle valid pulse.
- Used wherever several clients need occasional wide adds and area matters more than throughput.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, operand width in bits; must be a multiple of 4. N = WIDTH/4 nibble steps.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  NREQ  per-requester request; requester holds req and operands until it sees its grant bit.
- a_in  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- b_in  input  NREQ*WIDTH  operand B; same packing as a_in.
- grant  output  NREQ  one-hot, combinational; high only in the capture cycle.
- busy  output  1  high in CALC and DONE.
- res_valid  output  1  one-cycle result pulse.
- res_id  output  max(1,$clog2(NREQ))  index of the requester owning the result.
- res_sum  output  WIDTH  sum.
- res_carry  output  1  carry out of the MSB.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values: state IDLE; grant=0, busy=0, res_valid=0, res_id=0, res_sum=0, res_carry=0; nibble counter=0; carry register=0; round-robin pointer=NREQ-1, so requester 0 has top priority first.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - grant = highest-priority set req bit, searching from pointer+1 upward with wrap.
  - If any req is set: latch A, B and the winner index; set pointer=winner; clear counter and carry; go to CALC.
  - If no req is set: stay in IDLE, grant=0.
- CALC: each cycle computes {c,s} = A[4k+3:4k] + B[4k+3:4k] + carry for nibble k=counter.
  - Writes s into res_sum[4k+3:4k], c into the carry register, and increments the counter.
  - After nibble N-1: res_carry = c, res_id = latched index, go to DONE.
- DONE: res_valid=1 for exactly this cycle, then return to IDLE.
- Latency: grant in cycle t gives res_valid in cycle t+N+1. Throughput is one operation per N+2 cycles.
- res_sum, res_carry and res_id hold their values until the next result's DONE. Intermediate nibbles of res_sum change during CALC, so consumers sample only on res_valid.
- req is ignored outside IDLE. A req that drops before it is granted has no effect. A requester still holding req after its grant is lowest priority in the next IDLE cycle.
- Width rule: no truncation. Sum is modulo 2^WIDTH; overflow is reported only via res_carry.
- Reset mid-operation: rst_n low aborts on the next edge, all state returns to reset values, and no res_valid is produced.

Optional Feature:
- Macro: ADD_SUB_EN.
- Defined:
  - Adds input sub_in[NREQ-1:0], latched with the operands.
  - If the latched bit is 1, the slice uses ~B and the carry register initialises to 1, so res_sum = A-B mod 2^WIDTH.
  - In that case res_carry = 1 means no borrow (A>=B).
- Undefined: sub_in is absent and the block always adds.

Test Plan:
- Single add: reset, then req=0001, A0=0x1234, B0=0x0FFF. Required: grant=0001 in cycle t; res_valid in cycle t+5; res_sum=0x2233; res_carry=0; res_id=0.
- Full carry ripple: req=0100, A2=0xFFFF, B2=0x0001. Required: res_sum=0x0000, res_carry=1, res_id=2.
- Round-robin: req=1111 held continuously, each requester dropping req after its own grant and reasserting in DONE. Required: grants in order 0,1,2,3,0, six cycles apart; res_id matches each grant.
- Ignored request: req=0010 raised during CALC of an op for requester 0. Required: no grant until the next IDLE cycle; grant=0010 there.
- Reset mid-CALC: assert rst_n=0 two cycles after the grant. Required: next cycle all outputs are at reset values, no res_valid; a subsequent req is granted to requester 0 first.
- With ADD_SUB_EN: sub_in[1]=1, A1=0x0005, B1=0x0007. Required: res_sum=0xFFFE, res_carry=0.

Source files
------------

// File: rtl/nibble_add_scheduler_if.sv
// nibble_add_scheduler_if: requester-side bundle for the shared nibble adder.
// sub_in exists only when ADD_SUB_EN is defined.
interface nibble_add_scheduler_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] a_in;
   logic [NREQ*WIDTH-1:0] b_in;
`ifdef ADD_SUB_EN
   logic [NREQ-1:0]       sub_in;
`endif
   logic [NREQ-1:0]       grant;
   logic                  busy;
   logic                  res_valid;
   logic [IW-1:0]         res_id;
   logic [WIDTH-1:0]      res_sum;
   logic                  res_carry;
`ifdef ADD_SUB_EN
   modport master (output req, a_in, b_in, sub_in,
                   input  grant, busy, res_valid, res_id, res_sum, res_carry);
   modport slave  (input  req, a_in, b_in, sub_in,
                   output grant, busy, res_valid, res_id, res_sum, res_carry);
`else
   modport master (output req, a_in, b_in,
                   input  grant, busy, res_valid, res_id, res_sum, res_carry);
   modport slave  (input  req, a_in, b_in,
                   output grant, busy, res_valid, res_id, res_sum, res_carry);
`endif
endinterface

// File: rtl/nibble_add_scheduler.sv
// nibble_add_scheduler: round-robin shared 4-bit adder slice, one nibble per cycle.
// Define ADD_SUB_EN to add per-requester subtract via bus.sub_in.
module nibble_add_scheduler #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   nibble_add_scheduler_if.slave bus
);
   localparam int N  = WIDTH / 4;
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_sum_q, res_sum_d;
   logic [IW-1:0]    id_q, id_d, ptr_q, ptr_d, res_id_q, res_id_d, win, idx;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d, res_carry_q, res_carry_d;
   logic             busy_q, busy_d, res_valid_q, res_valid_d;
   logic             any_req;
   logic [3:0]       b_nib;
   logic [4:0]       nib_sum;
`ifdef ADD_SUB_EN
   logic             sub_q, sub_d;
`else
   logic             sub_q;
   assign sub_q = 1'b0;
`endif
   // Walk from the farthest candidate to the nearest so the one right after ptr wins.
   always_comb begin
      win = ptr_q;
      idx = ptr_q;
      any_req = 1'b0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = IW'((int'(ptr_q) + k) % NREQ);
         if (bus.req[idx]) begin
            win = idx;
            any_req = 1'b1;
         end
      end
   end
   assign bus.grant = (state_q == IDLE && any_req) ? (NREQ'(1) << win) : '0;
   // Subtraction feeds ~B with the carry register preloaded to 1.
   assign b_nib = b_q[{cnt_q, 2'b00} +: 4] ^ {4{sub_q}};
   assign nib_sum = {1'b0, a_q[{cnt_q, 2'b00} +: 4]} + {1'b0, b_nib} + {4'b0000, carry_q};
   always_comb begin
      state_d = state_q;
      a_d = a_q;
      b_d = b_q;
      id_d = id_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      carry_d = carry_q;
      res_sum_d = res_sum_q;
      res_carry_d = res_carry_q;
      res_id_d = res_id_q;
      busy_d = busy_q;
      res_valid_d = 1'b0;
`ifdef ADD_SUB_EN
      sub_d = sub_q;
`endif
      case (state_q)
         IDLE: if (any_req) begin
            a_d = bus.a_in[win*WIDTH +: WIDTH];
            b_d = bus.b_in[win*WIDTH +: WIDTH];
            id_d = win;
            ptr_d = win;
            cnt_d = '0;
`ifdef ADD_SUB_EN
            sub_d = bus.sub_in[win];
            carry_d = bus.sub_in[win];
`else
            carry_d = 1'b0;
`endif
            busy_d = 1'b1;
            state_d = CALC;
         end
         CALC: begin
            res_sum_d[{cnt_q, 2'b00} +: 4] = nib_sum[3:0];
            carry_d = nib_sum[4];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
               res_carry_d = nib_sum[4];
               res_id_d = id_q;
               res_valid_d = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            busy_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q <= '0;
         b_q <= '0;
         id_q <= '0;
         ptr_q <= IW'(NREQ - 1);
         cnt_q <= '0;
         carry_q <= 1'b0;
         res_sum_q <= '0;
         res_carry_q <= 1'b0;
         res_id_q <= '0;
         busy_q <= 1'b0;
         res_valid_q <= 1'b0;
`ifdef ADD_SUB_EN
         sub_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q <= a_d;
         b_q <= b_d;
         id_q <= id_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         carry_q <= carry_d;
         res_sum_q <= res_sum_d;
         res_carry_q <= res_carry_d;
         res_id_q <= res_id_d;
         busy_q <= busy_d;
         res_valid_q <= res_valid_d;
`ifdef ADD_SUB_EN
         sub_q <= sub_d;
`endif
      end
   end
   assign bus.busy = busy_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_id = res_id_q;
   assign bus.res_sum = res_sum_q;
   assign bus.res_carry = res_carry_q;
endmodule
